// File: rtl/bank_ram_phy.sv
// Banked SIMD word memory with per-bank write/read masks, a power-up clear
// sequence, and a fixed-latency read pipeline.
module bank_ram_phy #(
    parameter int unsigned NUM_BANKS  = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              cmd_valid,
    input  logic                              cmd_rw,
    input  logic [NUM_BANKS-1:0]              cmd_mask,
    input  logic [$clog2(DEPTH)-1:0]          cmd_addr,
    output logic                              cmd_ready,
    input  logic                              wvalid,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]   wdata,
    output logic                              wready,
    output logic                              rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]   rdata,
    output logic                              init_done,
    output logic                              wr_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned BUS_W  = NUM_BANKS * DATA_WIDTH;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [ADDR_W-1:0]      r_clr_cnt;
    logic [ADDR_W-1:0]      w_clr_cnt_nxt;
    logic                   r_cmd_ready;
    logic                   r_init_done;
    logic                   w_run_nxt;

    logic                   w_cmd_wr;
    logic                   w_wr_acc;
    logic                   w_wr_err;
    logic                   w_rd_acc;

    logic [NUM_BANKS-1:0]   w_mem_we;
    logic [ADDR_W-1:0]      w_mem_addr;
    logic [BUS_W-1:0]       w_mem_wdata;
    logic [BUS_W-1:0]       w_rd_word;
    logic [DATA_WIDTH-1:0]  r_mem [NUM_BANKS][DEPTH];

    logic [RD_LATENCY-1:0]  r_vld_pipe;
    logic [NUM_BANKS-1:0]   r_mask_pipe [RD_LATENCY];
    logic [BUS_W-1:0]       r_data_pipe [RD_LATENCY];
    logic [BUS_W-1:0]       w_rdata;

    // Command qualification; ready is low throughout the clear sequence.
    assign w_cmd_wr = cmd_valid & cmd_rw & r_cmd_ready;
    assign w_wr_acc = w_cmd_wr & wvalid;
    assign w_wr_err = w_cmd_wr & ~wvalid;
    assign w_rd_acc = cmd_valid & ~cmd_rw & r_cmd_ready;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= '0;
            r_cmd_ready <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_cmd_ready <= w_run_nxt;
            r_init_done <= w_run_nxt;
        end
    end

    // Next state: sweep every address once, then stay in RUN until reset.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_INIT: begin
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
        w_run_nxt = (w_state_nxt == ST_RUN);
    end

    // Write port arbitration: the clear sweep owns the port during INIT.
    always_comb begin
        w_mem_we    = '0;
        w_mem_addr  = cmd_addr;
        w_mem_wdata = wdata;
        if (r_state == ST_INIT) begin
            w_mem_we    = '1;
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = '0;
        end else if (w_wr_acc) begin
            w_mem_we    = cmd_mask;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_mem_we[b]) begin
                r_mem[b][w_mem_addr] <= w_mem_wdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_rd_word[b*DATA_WIDTH +: DATA_WIDTH] = r_mem[b][cmd_addr];
        end
    end

    // Read pipeline: payload stages only advance behind a valid, so the
    // final stage keeps the last returned word while rvalid is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_mask_pipe[i] <= '0;
                r_data_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_mask_pipe[0] <= cmd_mask;
                r_data_pipe[0] <= w_rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                if (r_vld_pipe[i-1]) begin
                    r_mask_pipe[i] <= r_mask_pipe[i-1];
                    r_data_pipe[i] <= r_data_pipe[i-1];
                end
            end
        end
    end

    // Banks not selected at acceptance read back as zero.
    always_comb begin
        w_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_mask_pipe[RD_LATENCY-1][b]) begin
                w_rdata[b*DATA_WIDTH +: DATA_WIDTH] =
                    r_data_pipe[RD_LATENCY-1][b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign init_done = r_init_done;
    assign wready    = w_wr_acc;
    assign wr_err    = w_wr_err;
    assign rvalid    = r_vld_pipe[RD_LATENCY-1];
    assign rdata     = w_rdata;

endmodule

// File: tb/tb_bank_ram_phy.sv
// Self-checking bench for bank_ram_phy: directed scenarios plus randomized
// traffic against an array/queue reference model.
module tb_bank_ram_phy;

    localparam int unsigned NB    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int unsigned LAT   = 2;
    localparam int unsigned BW    = NB * DW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_rw;
    logic [NB-1:0] cmd_mask;
    logic [AW-1:0] cmd_addr;
    logic          cmd_ready;
    logic          wvalid;
    logic [BW-1:0] wdata;
    logic          wready;
    logic          rvalid;
    logic [BW-1:0] rdata;
    logic          init_done;
    logic          wr_err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;

    logic [DW-1:0] mdl [NB][DEPTH];

    typedef struct {
        int            due;
        logic [BW-1:0] d;
    } rd_t;

    bank_ram_phy #(
        .NUM_BANKS (NB),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RD_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_rw   (cmd_rw),
        .cmd_mask (cmd_mask),
        .cmd_addr (cmd_addr),
        .cmd_ready(cmd_ready),
        .wvalid   (wvalid),
        .wdata    (wdata),
        .wready   (wready),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .init_done(init_done),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] exp_rd(input logic [AW-1:0] a, input logic [NB-1:0] m);
        logic [BW-1:0] r;
        r = '0;
        for (int b = 0; b < NB; b++) if (m[b]) r[b*DW +: DW] = mdl[b][a];
        return r;
    endfunction

    function automatic logic [BW-1:0] rnd_word();
        logic [BW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = $urandom();
        return r;
    endfunction

    task automatic mdl_write(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [BW-1:0] d);
        for (int b = 0; b < NB; b++) if (m[b]) mdl[b][a] = d[b*DW +: DW];
    endtask

    task automatic mdl_clear();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) mdl[b][a] = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic set_cmd(input logic v, input logic rw, input logic [NB-1:0] m,
                           input logic [AW-1:0] a, input logic wv, input logic [BW-1:0] d);
        cmd_valid = v;
        cmd_rw    = rw;
        cmd_mask  = m;
        cmd_addr  = a;
        wvalid    = wv;
        wdata     = d;
    endtask

    task automatic idle();
        set_cmd(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        int n;
        idle();
        rstn = 1'b0;
        repeat (3) cyc();
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); else n_pass++;
        n_total++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", init_done); else n_pass++;
        n_total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", rvalid); else n_pass++;
        n_total++; if (rdata !== '0) $display("FAIL reset_rdata got %h want 0", rdata); else n_pass++;
        n_total++; if (wready !== 1'b0 || wr_err !== 1'b0)
            $display("FAIL reset_wready_wr_err got %b%b want 00", wready, wr_err); else n_pass++;
        rstn = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            if (n == 10) begin
                set_cmd(1'b1, 1'b1, '1, 9'd3, 1'b1, rnd_word());
                #1;
                n_total++; if (wready !== 1'b0 || wr_err !== 1'b0)
                    $display("FAIL init_write_ignored got wready=%b wr_err=%b want 0 0", wready, wr_err); else n_pass++;
            end
            if (n == 11) set_cmd(1'b1, 1'b0, '1, 9'd3, 1'b0, '0);
            if (n == 12) idle();
            if (n == 13) begin
                n_total++; if (rvalid !== 1'b0) $display("FAIL init_read_ignored got rvalid=%b want 0", rvalid); else n_pass++;
            end
            cyc();
            n++;
        end
        n_total++; if (n != int'(DEPTH)) $display("FAIL init_length got %0d want %0d", n, DEPTH); else n_pass++;
        n_total++; if (init_done !== 1'b1) $display("FAIL init_done_rise got %b want 1", init_done); else n_pass++;
        mdl_clear();
    endtask

    task automatic test_read_after_init();
        logic [AW-1:0] a;
        logic [BW-1:0] e;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? AW'(DEPTH - 1) : 9'd3;
            set_cmd(1'b1, 1'b0, '1, a, 1'b0, '0);
            e = exp_rd(a, '1);
            cyc();
            idle();
            @(negedge clk);
            n_total++; if (rvalid !== 1'b0) $display("FAIL clear_read_early addr=%0d got rvalid=%b want 0", a, rvalid); else n_pass++;
            cyc();
            @(negedge clk);
            n_total++; if (rvalid !== 1'b1) $display("FAIL clear_read_valid addr=%0d got %b want 1", a, rvalid); else n_pass++;
            n_total++; if (rdata !== e) $display("FAIL clear_read_data addr=%0d got %h want %h", a, rdata, e); else n_pass++;
            cyc();
        end
    endtask

    task automatic test_write_read();
        logic [BW-1:0] d;
        logic [BW-1:0] e;
        d = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        set_cmd(1'b1, 1'b1, '1, 9'h0A, 1'b1, d);
        @(negedge clk);
        n_total++; if (wready !== 1'b1 || wr_err !== 1'b0)
            $display("FAIL wr_accept got wready=%b wr_err=%b want 1 0", wready, wr_err); else n_pass++;
        mdl_write(9'h0A, '1, d);
        cyc();
        set_cmd(1'b1, 1'b0, '1, 9'h0A, 1'b0, '0);
        e = exp_rd(9'h0A, '1);
        @(negedge clk);
        n_total++; if (wready !== 1'b0) $display("FAIL rd_no_wready got %b want 0", wready); else n_pass++;
        cyc();
        idle();
        @(negedge clk);
        n_total++; if (rvalid !== 1'b0) $display("FAIL raw_latency_early got %b want 0", rvalid); else n_pass++;
        cyc();
        @(negedge clk);
        n_total++; if (rvalid !== 1'b1) $display("FAIL raw_rvalid got %b want 1", rvalid); else n_pass++;
        n_total++; if (rdata !== e) $display("FAIL raw_rdata got %h want %h", rdata, e); else n_pass++;
        cyc();
        @(negedge clk);
        n_total++; if (rvalid !== 1'b0) $display("FAIL rvalid_pulse got %b want 0", rvalid); else n_pass++;
        n_total++; if (rdata !== e) $display("FAIL rdata_hold got %h want %h", rdata, e); else n_pass++;
    endtask

    task automatic test_partial_mask();
        logic [BW-1:0] d;
        logic [BW-1:0] e;
        d = rnd_word();
        d[2*DW +: DW] = 32'hDEADBEEF;
        set_cmd(1'b1, 1'b1, 5'b00100, 9'h0A, 1'b1, d);
        mdl_write(9'h0A, 5'b00100, d);
        cyc();
        set_cmd(1'b1, 1'b0, '1, 9'h0A, 1'b0, '0);
        e = exp_rd(9'h0A, '1);
        cyc();
        idle();
        cyc();
        @(negedge clk);
        n_total++; if (rvalid !== 1'b1) $display("FAIL mask_wr_rvalid got %b want 1", rvalid); else n_pass++;
        n_total++; if (rdata !== e) $display("FAIL mask_wr_rdata got %h want %h", rdata, e); else n_pass++;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] e [4];
        logic [BW-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = rnd_word();
            set_cmd(1'b1, 1'b1, '1, AW'(i), 1'b1, d);
            mdl_write(AW'(i), '1, d);
            cyc();
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                set_cmd(1'b1, 1'b0, '1, AW'(k), 1'b0, '0);
                e[k] = exp_rd(AW'(k), '1);
            end else begin
                idle();
            end
            @(negedge clk);
            n_total++; if (rvalid !== (k >= 2)) $display("FAIL b2b_rvalid k=%0d got %b want %b", k, rvalid, (k >= 2)); else n_pass++;
            if (k >= 2) begin
                n_total++; if (rdata !== e[k-2]) $display("FAIL b2b_rdata k=%0d got %h want %h", k, rdata, e[k-2]); else n_pass++;
            end
            cyc();
        end
        set_cmd(1'b1, 1'b0, 5'b00001, 9'd2, 1'b0, '0);
        cyc();
        idle();
        cyc();
        @(negedge clk);
        n_total++; if (rvalid !== 1'b1) $display("FAIL narrow_rvalid got %b want 1", rvalid); else n_pass++;
        n_total++; if (rdata[BW-1:DW] !== '0) $display("FAIL narrow_zero got %h want 0", rdata[BW-1:DW]); else n_pass++;
        n_total++; if (rdata[DW-1:0] !== mdl[0][2]) $display("FAIL narrow_bank0 got %h want %h", rdata[DW-1:0], mdl[0][2]); else n_pass++;
        cyc();
    endtask

    task automatic test_wr_err();
        logic [BW-1:0] e;
        set_cmd(1'b1, 1'b1, '1, 9'h0A, 1'b0, rnd_word());
        @(negedge clk);
        n_total++; if (wr_err !== 1'b1) $display("FAIL wr_err_pulse got %b want 1", wr_err); else n_pass++;
        n_total++; if (wready !== 1'b0) $display("FAIL wr_err_wready got %b want 0", wready); else n_pass++;
        cyc();
        set_cmd(1'b0, 1'b1, '1, 9'h0A, 1'b1, rnd_word());
        @(negedge clk);
        n_total++; if (wr_err !== 1'b0) $display("FAIL wr_err_single got %b want 0", wr_err); else n_pass++;
        n_total++; if (wready !== 1'b0) $display("FAIL lone_wvalid got %b want 0", wready); else n_pass++;
        cyc();
        set_cmd(1'b1, 1'b0, '1, 9'h0A, 1'b1, rnd_word());
        e = exp_rd(9'h0A, '1);
        @(negedge clk);
        n_total++; if (wready !== 1'b0) $display("FAIL read_wvalid got %b want 0", wready); else n_pass++;
        cyc();
        idle();
        cyc();
        @(negedge clk);
        n_total++; if (rvalid !== 1'b1 || rdata !== e)
            $display("FAIL wr_err_unchanged got %b/%h want 1/%h", rvalid, rdata, e); else n_pass++;
        cyc();
    endtask

    task automatic test_random();
        rd_t           q[$];
        rd_t           ent;
        logic [BW-1:0] hold;
        logic          seen;
        logic          v, rw, wv, ev;
        logic [NB-1:0] m;
        logic [AW-1:0] a;
        seen = 1'b0;
        hold = '0;
        for (int k = 0; k < 300 + int'(LAT) + 1; k++) begin
            if (k < 300) begin
                v  = ($urandom_range(0, 3) != 0);
                rw = 1'($urandom_range(0, 1));
                wv = ($urandom_range(0, 4) != 0);
                m  = NB'($urandom());
                a  = AW'($urandom_range(0, 7));
                set_cmd(v, rw, m, a, wv, rnd_word());
            end else begin
                v = 1'b0; rw = 1'b0; wv = 1'b0; m = '0; a = '0;
                idle();
            end
            @(negedge clk);
            n_total++; if (wready !== (v & rw & wv)) $display("FAIL rnd_wready k=%0d got %b want %b", k, wready, v & rw & wv); else n_pass++;
            n_total++; if (wr_err !== (v & rw & ~wv)) $display("FAIL rnd_wr_err k=%0d got %b want %b", k, wr_err, v & rw & ~wv); else n_pass++;
            ev = (q.size() > 0) && (q[0].due == cyc_n);
            n_total++; if (rvalid !== ev) $display("FAIL rnd_rvalid k=%0d got %b want %b", k, rvalid, ev); else n_pass++;
            if (ev) begin
                ent = q.pop_front();
                n_total++; if (rdata !== ent.d) $display("FAIL rnd_rdata k=%0d got %h want %h", k, rdata, ent.d); else n_pass++;
                hold = ent.d;
                seen = 1'b1;
            end else if (seen) begin
                n_total++; if (rdata !== hold) $display("FAIL rnd_hold k=%0d got %h want %h", k, rdata, hold); else n_pass++;
            end
            if (v && !rw) begin
                ent.due = cyc_n + int'(LAT);
                ent.d   = exp_rd(a, m);
                q.push_back(ent);
            end
            if (v && rw && wv) mdl_write(a, m, wdata);
            cyc();
        end
        n_total++; if (q.size() != 0) $display("FAIL rnd_drain got %0d pending want 0", q.size()); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int n;
        int stray;
        set_cmd(1'b1, 1'b0, '1, 9'h0A, 1'b0, '0);
        cyc();
        idle();
        rstn = 1'b0;
        #1;
        n_total++; if (rvalid !== 1'b0 || rdata !== '0)
            $display("FAIL midrst_clear got %b/%h want 0/0", rvalid, rdata); else n_pass++;
        stray = 0;
        repeat (2) begin
            cyc();
            if (rvalid !== 1'b0) stray++;
        end
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", cmd_ready); else n_pass++;
        rstn = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            if (rvalid !== 1'b0) stray++;
            cyc();
            n++;
        end
        n_total++; if (stray != 0) $display("FAIL midrst_stray_rvalid got %0d want 0", stray); else n_pass++;
        n_total++; if (n != int'(DEPTH)) $display("FAIL midrst_init_length got %0d want %0d", n, DEPTH); else n_pass++;
        mdl_clear();
        set_cmd(1'b1, 1'b0, '1, 9'h0A, 1'b0, '0);
        cyc();
        idle();
        cyc();
        @(negedge clk);
        n_total++; if (rvalid !== 1'b1 || rdata !== exp_rd(9'h0A, '1))
            $display("FAIL midrst_recleared got %b/%h want 1/%h", rvalid, rdata, exp_rd(9'h0A, '1)); else n_pass++;
        cyc();
    endtask

    initial begin
        test_reset();
        test_read_after_init();
        test_write_read();
        test_partial_mask();
        test_back_to_back();
        test_wr_err();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
